id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage feeding the execute-stage ALU of the five-stage pipelined CPU. Registers the decoded instruction and its operands, decodes `alu_op`/`funct` into the 3-bit ALU control code, and resolves operands through EX/MEM and MEM/WB forwarding before they reach the ALU's `data1_i`/`data2_i`/`ALUCtrl_i`. Supports stall (hold) and flush (bubble), and reports load-use hazards to the hazard unit.

## Interface
- `RESET_PC_UNUSED`: none; the block has no parameters. All widths are fixed at 32-bit data, 5-bit register index.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `stall_i`  in  1  hold current contents.
- `flush_i`  in  1  load a bubble.
- `valid_i`  in  1  ID holds a real instruction.
- `rs_data_i`, `rt_data_i`  in  32  register-file read data.
- `imm_i`  in  16  immediate; sign-extended internally.
- `rs_addr_i`, `rt_addr_i`, `rd_addr_i`  in  5  register indices.
- `funct_i`  in  6  R-type function field.
- `alu_op_i`  in  2  main-decoder ALU class.
- `alu_src_i`, `reg_dst_i`, `reg_write_i`, `mem_read_i`, `mem_write_i`, `mem_to_reg_i`  in  1  main-decoder controls.
- `exmem_reg_write_i`  in  1  write-enable of the instruction in MEM.
- `exmem_rd_i`  in  5  destination of the instruction in MEM.
- `exmem_data_i`  in  32  ALU result of the instruction in MEM.
- `memwb_reg_write_i`  in  1  write-enable of the instruction in WB.
- `memwb_rd_i`  in  5  destination of the instruction in WB.
- `memwb_data_i`  in  32  data of the instruction in WB.
- `data1_o`, `data2_o`  out  32  ALU operands.
- `alu_ctrl_o`  out  3  ALU control code.
- `store_data_o`  out  32  forwarded rt value, used by `sw`.
- `wr_addr_o`  out  5  destination register (rd or rt).
- `reg_write_o`, `mem_read_o`, `mem_write_o`, `mem_to_reg_o`, `valid_o`  out  1  registered controls.
- `load_use_o`  out  1  combinational load-use hazard flag.

## Operation
- **Priority on each edge:** `rst_i` > `flush_i` > `stall_i` > normal load.
- **Reset or flush:** clears all registers, including `valid_o`, all control outputs and `alu_ctrl_o`, to 0. Every output therefore reads 0 at reset.
- **Normal load:** captures all `*_i` fields.
  - `valid_i`=0 loads the controls as 0.
- **ALU control decode** (registered as `alu_ctrl_o`):
  - `alu_op` 00 → 0 (add).
  - `alu_op` 01 → 1 (sub).
  - `alu_op` 11 → 4 (or).
  - `alu_op` 10 decodes `funct`: 100000 → 0, 100010 → 1, 011000 → 2 (mul), 100100 → 3, 100101 → 4, anything else → 5 (ALU outputs 0).
- **Destination:** `wr_addr_o` = `reg_dst` ? rd : rt.
- **Forwarding** (combinational on the registered indices), for each of rs and rt:
  - If the EX/MEM write is enabled, its destination is nonzero, and it equals the index, take `exmem_data_i`.
  - Else apply the same test to MEM/WB and take `memwb_data_i`.
  - Else use the registered value.
  - EX/MEM wins when both stages match.
- **Operand selection:**
  - `data1_o` = forwarded rs.
  - `data2_o` = `alu_src` ? sext(imm) : forwarded rt.
  - `store_data_o` = forwarded rt.
- **Stall refresh:** while `stall_i` holds the stage, a MEM/WB write with a nonzero destination matching the held rs or rt overwrites that held operand register. This prevents a stale value once the writer retires.
- **Load-use detection:** `load_use_o` = `valid_o` & `mem_read_o` & `wr_addr_o`≠0 & (`wr_addr_o`==`rs_addr_i` | `wr_addr_o`==`rt_addr_i`).

## Timing
- Latency is one cycle, ID → EX.
- Forwarding and operand muxing are purely combinational within the EX cycle.
- `load_use_o` is combinational in the same cycle and carries no state.
- Asserting `rst_i` mid-stall clears immediately, without waiting for a clock edge.
- `flush_i` and `stall_i` asserted together produce a flush.

## Configuration
- **`ID_EX_FORWARD_EN` defined:** forwarding muxes and the stall refresh are present.
- **`ID_EX_FORWARD_EN` undefined:**
  - Operands come straight from the registered values.
  - The `exmem_*` and `memwb_*` inputs are ignored.
  - `load_use_o` is unchanged.

## Structure
- **Shared package `cpu_pkg`:** ALU control constants `ALU_ADD`=0, `ALU_SUB`=1, `ALU_MUL`=2, `ALU_AND`=3, `ALU_OR`=4, `ALU_NOP`=5, plus the funct and `alu_op` encodings.
- **Sub-module `alu_ctrl_dec`:** the combinational `alu_op`/`funct` → code decoder.

## Test plan
- **Reset:** assert `rst_i` with nonzero inputs → all outputs 0; deassert, load add r3,r1,r2 (`funct` 100000, `alu_op` 10) → `alu_ctrl_o`=0, `wr_addr_o`=3 the next cycle.
- **Forwarding priority:** EX rs=1, EX/MEM rd=1 data 0xAAAA, MEM/WB rd=1 data 0x5555 → `data1_o`=0xAAAA. Repeat with rd=0 on both → the registered value.
- **Immediate path:** `alu_src`=1, imm 0xFFFC → `data2_o`=0xFFFFFFFC, while `store_data_o` still carries forwarded rt.
- **Stall and refresh:** stall for 2 cycles while MEM/WB writes r4=0x1234 to the held rt=4 → after the stall, `data2_o`=0x1234 with no forwarding active.
- **Flush over stall:** `flush_i` and `stall_i` both high → `valid_o`=0 and `reg_write_o`=0 the next cycle.
- **Load-use:** EX holds lw to r5; ID rs=5 → `load_use_o`=1. Same case with `wr_addr_o`=0 → `load_use_o`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU-control codes, decoder encodings and small helpers for the pipeline stages.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_NOP = 3'd5
    } alu_ctrl_e;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_OR    = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic [2:0]  alu_ctrl;
        logic [4:0]  wr_addr;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
    } id_ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // r0 is hard-wired zero, so a write to it never forwards.
    function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] idx);
        return we && rd != 5'd0 && rd == idx;
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: maps the main-decoder ALU class and R-type funct onto the 3-bit ALU control code.
module alu_ctrl_dec
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o
);
    always_comb begin
        alu_ctrl_o = alu_op_i == AOP_ADD ? ALU_ADD :
                     alu_op_i == AOP_SUB ? ALU_SUB :
                     alu_op_i == AOP_OR  ? ALU_OR  :
                     funct_i  == FN_ADD  ? ALU_ADD :
                     funct_i  == FN_SUB  ? ALU_SUB :
                     funct_i  == FN_MUL  ? ALU_MUL :
                     funct_i  == FN_AND  ? ALU_AND :
                     funct_i  == FN_OR   ? ALU_OR  : ALU_NOP;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with ALU-control decode, operand forwarding and load-use detection.
// Forwarding muxes and the stall refresh exist only when ID_EX_FORWARD_EN is defined.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [15:0] imm_i,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [5:0]  funct_i,
    input  logic [1:0]  alu_op_i,
    input  logic        alu_src_i,
    input  logic        reg_dst_i,
    input  logic        reg_write_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        mem_to_reg_i,
    input  logic        exmem_reg_write_i,
    input  logic [4:0]  exmem_rd_i,
    input  logic [31:0] exmem_data_i,
    input  logic        memwb_reg_write_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic [31:0] memwb_data_i,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [2:0]  alu_ctrl_o,
    output logic [31:0] store_data_o,
    output logic [4:0]  wr_addr_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        mem_to_reg_o,
    output logic        valid_o,
    output logic        load_use_o
);
    id_ex_t      ex, nxt;
    logic [2:0]  dec_ctrl;
    logic [31:0] rs_fwd, rt_fwd;

    alu_ctrl_dec u_dec (
        .alu_op_i   (alu_op_i),
        .funct_i    (funct_i),
        .alu_ctrl_o (dec_ctrl)
    );

    // A bubble from ID (valid_i=0) must not write or touch memory.
    always_comb begin
        nxt            = '0;
        nxt.valid      = valid_i;
        nxt.reg_write  = valid_i & reg_write_i;
        nxt.mem_read   = valid_i & mem_read_i;
        nxt.mem_write  = valid_i & mem_write_i;
        nxt.mem_to_reg = valid_i & mem_to_reg_i;
        nxt.alu_src    = alu_src_i;
        nxt.alu_ctrl   = dec_ctrl;
        nxt.wr_addr    = reg_dst_i ? rd_addr_i : rt_addr_i;
        nxt.rs_addr    = rs_addr_i;
        nxt.rt_addr    = rt_addr_i;
        nxt.rs_data    = rs_data_i;
        nxt.rt_data    = rt_data_i;
        nxt.imm        = sext16(imm_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ex <= '0;
        else if (flush_i) ex <= '0;
        else if (!stall_i) ex <= nxt;
`ifdef ID_EX_FORWARD_EN
        // A writer retiring during the stall would otherwise leave a stale held operand.
        else begin
            if (fwd_hit(memwb_reg_write_i, memwb_rd_i, ex.rs_addr)) ex.rs_data <= memwb_data_i;
            if (fwd_hit(memwb_reg_write_i, memwb_rd_i, ex.rt_addr)) ex.rt_data <= memwb_data_i;
        end
`endif
    end

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        rs_fwd = fwd_hit(exmem_reg_write_i, exmem_rd_i, ex.rs_addr) ? exmem_data_i :
                 fwd_hit(memwb_reg_write_i, memwb_rd_i, ex.rs_addr) ? memwb_data_i : ex.rs_data;
        rt_fwd = fwd_hit(exmem_reg_write_i, exmem_rd_i, ex.rt_addr) ? exmem_data_i :
                 fwd_hit(memwb_reg_write_i, memwb_rd_i, ex.rt_addr) ? memwb_data_i : ex.rt_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write_i, exmem_rd_i, exmem_data_i, memwb_reg_write_i,
                          memwb_rd_i, memwb_data_i, ex.rs_addr, ex.rt_addr};
    assign rs_fwd = ex.rs_data;
    assign rt_fwd = ex.rt_data;
`endif

    assign data1_o      = rs_fwd;
    assign data2_o      = ex.alu_src ? ex.imm : rt_fwd;
    assign store_data_o = rt_fwd;
    assign alu_ctrl_o   = ex.alu_ctrl;
    assign wr_addr_o    = ex.wr_addr;
    assign reg_write_o  = ex.reg_write;
    assign mem_read_o   = ex.mem_read;
    assign mem_write_o  = ex.mem_write;
    assign mem_to_reg_o = ex.mem_to_reg;
    assign valid_o      = ex.valid;
    assign load_use_o   = ex.valid & ex.mem_read & (ex.wr_addr != 5'd0) &
                          (ex.wr_addr == rs_addr_i || ex.wr_addr == rt_addr_i);
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage with an instruction-level reference model.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk_i = 1'b0, rst_i, stall_i, flush_i, valid_i;
    logic [31:0] rs_data_i, rt_data_i, exmem_data_i, memwb_data_i;
    logic [15:0] imm_i;
    logic [4:0] rs_addr_i, rt_addr_i, rd_addr_i, exmem_rd_i, memwb_rd_i;
    logic [5:0] funct_i;
    logic [1:0] alu_op_i;
    logic alu_src_i, reg_dst_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
    logic exmem_reg_write_i, memwb_reg_write_i;
    logic [31:0] data1_o, data2_o, store_data_o;
    logic [2:0] alu_ctrl_o;
    logic [4:0] wr_addr_o;
    logic reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o, load_use_o;

    int checks = 0, failures = 0;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .funct_i(funct_i), .alu_op_i(alu_op_i), .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_to_reg_i(mem_to_reg_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
        .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .data1_o(data1_o), .data2_o(data2_o), .alu_ctrl_o(alu_ctrl_o), .store_data_o(store_data_o),
        .wr_addr_o(wr_addr_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o), .valid_o(valid_o),
        .load_use_o(load_use_o)
    );

    always #5 clk_i = ~clk_i;

    // The instruction currently sitting in EX, as the model sees it.
    typedef struct {
        bit v, rw, mr, mw, m2r, src;
        logic [2:0] ctl;
        logic [4:0] rs, rt, wa;
        logic [31:0] rsd, rtd, imm;
    } ex_t;
    ex_t m;

    function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 3'd0;
        if (op == 2'b01) return 3'd1;
        if (op == 2'b11) return 3'd4;
        case (fn)
            6'b100000: return 3'd0;
            6'b100010: return 3'd1;
            6'b011000: return 3'd2;
            6'b100100: return 3'd3;
            6'b100101: return 3'd4;
            default:   return 3'd5;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] held);
        if (exmem_reg_write_i && exmem_rd_i != 0 && exmem_rd_i == idx) return exmem_data_i;
        if (memwb_reg_write_i && memwb_rd_i != 0 && memwb_rd_i == idx) return memwb_data_i;
        return held;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on the clock edge, in the order rst > flush > stall > load.
    task automatic model_edge();
        if (rst_i || flush_i) m = '{default: 0};
        else if (!stall_i) begin
            m.v = valid_i; m.rw = valid_i & reg_write_i; m.mr = valid_i & mem_read_i;
            m.mw = valid_i & mem_write_i; m.m2r = valid_i & mem_to_reg_i; m.src = alu_src_i;
            m.ctl = ref_ctrl(alu_op_i, funct_i);
            m.rs = rs_addr_i; m.rt = rt_addr_i; m.wa = reg_dst_i ? rd_addr_i : rt_addr_i;
            m.rsd = rs_data_i; m.rtd = rt_data_i; m.imm = {{16{imm_i[15]}}, imm_i};
        end else if (FWD && memwb_reg_write_i && memwb_rd_i != 0) begin
            if (memwb_rd_i == m.rs) m.rsd = memwb_data_i;
            if (memwb_rd_i == m.rt) m.rtd = memwb_data_i;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #2;
    endtask

    always @(negedge clk_i) begin
        logic [31:0] e1, e2;
        e1 = FWD ? ref_fwd(m.rs, m.rsd) : m.rsd;
        e2 = FWD ? ref_fwd(m.rt, m.rtd) : m.rtd;
        chk("cyc_data1", data1_o, e1);
        chk("cyc_data2", data2_o, m.src ? m.imm : e2);
        chk("cyc_store", store_data_o, e2);
        chk("cyc_ctrl", {29'd0, alu_ctrl_o}, {29'd0, m.ctl});
        chk("cyc_wr_addr", {27'd0, wr_addr_o}, {27'd0, m.wa});
        chk("cyc_flags", {27'd0, valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o},
            {27'd0, m.v, m.rw, m.mr, m.mw, m.m2r});
        chk("cyc_load_use", {31'd0, load_use_o},
            {31'd0, m.v & m.mr & (m.wa != 0) & (m.wa == rs_addr_i || m.wa == rt_addr_i)});
    end

    task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                           input logic ww, input logic [4:0] wr, input logic [31:0] wd);
        exmem_reg_write_i = ew; exmem_rd_i = er; exmem_data_i = ed;
        memwb_reg_write_i = ww; memwb_rd_i = wr; memwb_data_i = wd;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                          input logic [1:0] op, input logic [5:0] fn, input logic src,
                          input logic dst, input logic rw, input logic mr, input logic mw);
        valid_i = 1'b1; rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd;
        rs_data_i = rsd; rt_data_i = rtd; imm_i = imm; alu_op_i = op; funct_i = fn;
        alu_src_i = src; reg_dst_i = dst; reg_write_i = rw; mem_read_i = mr;
        mem_write_i = mw; mem_to_reg_i = mr;
    endtask

    task automatic dec(input logic [1:0] op, input logic [5:0] fn, input logic [2:0] exp);
        set_id(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0, op, fn, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("dec_ctrl", {29'd0, alu_ctrl_o}, {29'd0, exp});
    endtask

    initial begin
        m = '{default: 0};
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        set_id(5'd7, 5'd8, 5'd9, 32'hFFFF_0001, 32'hFFFF_0002, 16'h8001, 2'b10, 6'b100010,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        set_fwd(1'b1, 5'd7, 32'h1111, 1'b1, 5'd8, 32'h2222);
        tick(); tick();
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_reg_write", {31'd0, reg_write_o}, 32'd0);
        chk("rst_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
        chk("rst_data1", data1_o, 32'd0);
        chk("rst_data2", data2_o, 32'd0);
        chk("rst_wr_addr", {27'd0, wr_addr_o}, 32'd0);

        rst_i = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_id(5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 16'd0, 2'b10, 6'b100000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("add_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
        chk("add_wr_addr", {27'd0, wr_addr_o}, 32'd3);
        chk("add_data1", data1_o, 32'd10);
        chk("add_data2", data2_o, 32'd20);

        dec(2'b00, 6'b100010, 3'd0);
        dec(2'b01, 6'b100000, 3'd1);
        dec(2'b11, 6'b011000, 3'd4);
        dec(2'b10, 6'b100010, 3'd1);
        dec(2'b10, 6'b011000, 3'd2);
        dec(2'b10, 6'b100100, 3'd3);
        dec(2'b10, 6'b100101, 3'd4);
        dec(2'b10, 6'b000000, 3'd5);
        dec(2'b10, 6'b100000, 3'd0);

        // Forwarding priority: EX/MEM beats MEM/WB; r0 never forwards.
        set_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 16'd0, 2'b10, 6'b100000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_fwd(1'b1, 5'd1, 32'hAAAA, 1'b1, 5'd1, 32'h5555);
        #1 chk("fwd_prio", data1_o, FWD ? 32'hAAAA : 32'h11);
        set_fwd(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'h5555);
        #1 chk("fwd_r0", data1_o, 32'h11);
        set_fwd(1'b0, 5'd2, 32'hAAAA, 1'b1, 5'd2, 32'h5555);
        #1 chk("fwd_wb_rt", store_data_o, FWD ? 32'h5555 : 32'h22);

        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_id(5'd1, 5'd2, 5'd2, 32'h11, 32'h22, 16'hFFFC, 2'b00, 6'd0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h777);
        #1 chk("imm_data2", data2_o, 32'hFFFF_FFFC);
        chk("imm_store", store_data_o, FWD ? 32'h777 : 32'h22);

        // Stall with a MEM/WB write to the held rt.
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_id(5'd6, 5'd4, 5'd9, 32'h66, 32'h99, 16'd0, 2'b10, 6'b100000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        stall_i = 1'b1;
        set_id(5'd7, 5'd7, 5'd7, 32'hDEAD, 32'hDEAD, 16'd0, 2'b01, 6'd0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h1234);
        tick(); tick();
        stall_i = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1 chk("stall_refresh", data2_o, FWD ? 32'h1234 : 32'h99);
        chk("stall_hold_rs", data1_o, 32'h66);

        // Reset arriving mid-stall takes effect without a clock edge.
        stall_i = 1'b1;
        #1 rst_i = 1'b1; m = '{default: 0};
        #1 chk("async_rst_data1", data1_o, 32'd0);
        chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
        rst_i = 1'b0; stall_i = 1'b0;

        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 16'd0, 2'b10, 6'b100000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("pre_flush_valid", {31'd0, valid_o}, 32'd1);
        flush_i = 1'b1; stall_i = 1'b1;
        tick();
        chk("flush_valid", {31'd0, valid_o}, 32'd0);
        chk("flush_reg_write", {31'd0, reg_write_o}, 32'd0);
        flush_i = 1'b0; stall_i = 1'b0;

        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 16'd0, 2'b10, 6'b100000,
               1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        valid_i = 1'b0;
        tick();
        chk("bubble_reg_write", {31'd0, reg_write_o}, 32'd0);
        chk("bubble_mem_read", {31'd0, mem_read_o}, 32'd0);

        // lw r5: load-use against ID source indices.
        set_id(5'd1, 5'd5, 5'd0, 32'd100, 32'd0, 16'd4, 2'b00, 6'd0,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        rs_addr_i = 5'd5; rt_addr_i = 5'd9;
        #1 chk("lu_rs", {31'd0, load_use_o}, 32'd1);
        rs_addr_i = 5'd8; rt_addr_i = 5'd5;
        #1 chk("lu_rt", {31'd0, load_use_o}, 32'd1);
        rs_addr_i = 5'd8; rt_addr_i = 5'd9;
        #1 chk("lu_none", {31'd0, load_use_o}, 32'd0);
        set_id(5'd1, 5'd0, 5'd0, 32'd100, 32'd0, 16'd4, 2'b00, 6'd0,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        rs_addr_i = 5'd0; rt_addr_i = 5'd0;
        #1 chk("lu_r0", {31'd0, load_use_o}, 32'd0);

        valid_i = 1'b0;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
